// File: rtl/rsa_cmd_ctrl.sv
// rsa_cmd_ctrl: command controller for a bank of RSA compute cores.
// A 32-bit command on port1 selects an opcode and a core. READ loads a BRAM
// word as the core operand. COMPUTE starts the core and does not wait for it.
// WRITE returns the core result to BRAM once the core is idle. STATUS reports
// the busy bitmap. Every command ends with one response word on port2.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   port1_din/valid/read               command word in, accept strobe out
//   port2_dout/valid/read              response word out, consume strobe in
//   bram_din/bram_din_valid            operand word in
//   bram_dout/valid/read               result word out, held until read
//   core_start/core_din                per-core start pulse and operand
//   core_done/core_dout                per-core completion pulse and results
//   leds                               busy bitmap (low 4 bits)
module rsa_cmd_ctrl #(
  parameter int DATA_W     = 1024,
  parameter int NUM_CORES  = 2,
  parameter int CORE_IDX_W = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [31:0]                 port1_din,
  input  logic                        port1_valid,
  output logic                        port1_read,
  output logic                        port2_valid,
  input  logic                        port2_read,
  output logic [31:0]                 port2_dout,
  input  logic [DATA_W-1:0]           bram_din,
  input  logic                        bram_din_valid,
  output logic [DATA_W-1:0]           bram_dout,
  output logic                        bram_dout_valid,
  input  logic                        bram_dout_read,
  output logic [NUM_CORES-1:0]        core_start,
  output logic [DATA_W-1:0]           core_din,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES*DATA_W-1:0] core_dout,
  output logic [3:0]                  leds
);

  // Storage is sized to the full index range so any decoded index selects a
  // real slot; slots at or above NUM_CORES are never written.
  localparam int NSLOT = 2**CORE_IDX_W;
  localparam logic [31:0] RESP_ERR = 32'h8000_0000;

  typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, WRITE_OUT, RESP} state_e;
  typedef enum logic [1:0] {OP_READ, OP_COMPUTE, OP_WRITE, OP_STATUS} op_e;

  state_e                  state_q, state_d;
  op_e                     op;
  logic [CORE_IDX_W-1:0]   idx;
  logic                    idx_ok;
  logic                    accept;
  logic [CORE_IDX_W-1:0]   k_q, k_d;
  logic [NSLOT-1:0]        busy_q, busy_d;
  logic [NSLOT-1:0]        start_vec;
  logic [31:0]             resp_q, resp_d;
  logic [DATA_W-1:0]       din_q, din_d;
  logic [DATA_W-1:0]       operand_q [NSLOT];
  logic [DATA_W-1:0]       operand_d [NSLOT];
  logic [DATA_W-1:0]       result_q  [NSLOT];
  logic [DATA_W-1:0]       result_d  [NSLOT];
  logic                    cmd_unused;

  assign op         = op_e'(port1_din[1:0]);
  assign idx        = port1_din[4 +: CORE_IDX_W];
  assign idx_ok     = int'(idx) < NUM_CORES;
  assign accept     = (state_q == IDLE) && port1_valid && !reset;
  assign cmd_unused = ^{port1_din[31:4+CORE_IDX_W], port1_din[3:2]};

  always_comb begin
    start_vec = '0;
    if (accept && op == OP_COMPUTE && idx_ok && !busy_q[idx]) start_vec[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      busy_q  <= '0;
      resp_q  <= '0;
      din_q   <= '0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        operand_q[i] <= '0;
        result_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      resp_q  <= resp_d;
      din_q   <= din_d;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        operand_q[i] <= operand_d[i];
        result_q[i]  <= result_d[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    resp_d    = resp_q;
    din_d     = din_q;
    busy_d    = busy_q;
    operand_d = operand_q;
    result_d  = result_q;

    // Completions are taken in every state; a start on the same core in the
    // same cycle is applied afterwards so it wins over the clear.
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (core_done[k] && busy_q[k]) begin
        result_d[k] = core_dout[k*DATA_W +: DATA_W];
        busy_d[k]   = 1'b0;
      end
    end
    busy_d = busy_d | start_vec;
    if (|start_vec) din_d = operand_q[idx];

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          k_d = idx;
          if (!idx_ok) begin
            state_d = RESP;
            resp_d  = RESP_ERR;
          end else begin
            unique case (op)
              OP_READ:    state_d = READ_WAIT;
              OP_COMPUTE: begin
                state_d = RESP;
                resp_d  = busy_q[idx] ? RESP_ERR : '0;
              end
              OP_WRITE:   state_d = busy_q[idx] ? WRITE_WAIT : WRITE_OUT;
              OP_STATUS:  begin
                state_d = RESP;
                resp_d  = 32'(busy_q);
              end
              default:    state_d = IDLE;
            endcase
          end
        end
      end
      READ_WAIT: begin
        if (bram_din_valid) begin
          operand_d[k_q] = bram_din;
          resp_d         = '0;
          state_d        = RESP;
        end
      end
      WRITE_WAIT: begin
        if (!busy_q[k_q]) state_d = WRITE_OUT;
      end
      WRITE_OUT: begin
        if (bram_dout_read) begin
          resp_d  = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (port2_read) begin
          resp_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    port1_read      = accept;
    port2_valid     = (state_q == RESP);
    port2_dout      = resp_q;
    bram_dout_valid = (state_q == WRITE_OUT);
    bram_dout       = (state_q == WRITE_OUT) ? result_q[k_q] : '0;
    core_start      = start_vec[NUM_CORES-1:0];
    core_din        = (|start_vec) ? operand_q[idx] : din_q;
  end

  for (genvar i = 0; i < 4; i++) begin : g_leds
    if (i < NSLOT) begin : g_bit
      assign leds[i] = busy_q[i];
    end else begin : g_zero
      assign leds[i] = 1'b0;
    end
  end

endmodule
